vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Upstream raster timing stage for the VGA output path. It divides the 50 MHz system clock into a 25 MHz pixel tick and runs horizontal and vertical counters for 640x480@60. It drives the undelayed DrawX/DrawY coordinates consumed by background_mapper, and produces hs/vs/blank delayed by a configurable number of pixel ticks so they arrive aligned with the mapper's registered ROM/palette RGB output. It also provides a frame-start pulse and frame counter for game logic.

## Interface
- PIPE_DELAY, 2: pixel-tick latency from DrawX/DrawY to valid mapper RGB; legal range 0..4.
- H_VISIBLE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels; H_TOTAL = sum = 800.
- V_VISIBLE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines; V_TOTAL = sum = 525.
- Clk  in  1  system clock, 50 MHz; the block's only clock.
- Reset  in  1  synchronous, active-high reset.
- pixel_clk  out  1  25 MHz square wave, toggles every Clk; drives the VGA DAC clock.
- pix_en  out  1  one-Clk-wide pixel tick, high every second Clk.
- DrawX  out  10  current horizontal count 0..799, undelayed.
- DrawY  out  10  current vertical count 0..524, undelayed.
- draw_valid  out  1  high when DrawX<640 and DrawY<480, undelayed.
- hs  out  1  horizontal sync, active low, delayed PIPE_DELAY ticks.
- vs  out  1  vertical sync, active low, delayed PIPE_DELAY ticks.
- blank  out  1  active low: 0 during blanking, 1 in the visible area; delayed PIPE_DELAY ticks.
- frame_start  out  1  one-Clk pulse at the start of each frame.
- frame_count  out  8  frames completed since reset, modulo 256.

## Operation
- Tick divider: a 1-bit toggle register. pixel_clk equals this register. pix_en = toggle==1, so pix_en is high on the Clk edge on which pixel_clk falls.
- Counters advance only when pix_en=1.
  - hc increments and wraps 799->0.
  - On the hc wrap, vc increments and wraps 524->0.
  - DrawX=hc and DrawY=vc, registered with no delay.
- Raw timing decode, all from current hc/vc:
  - hs_raw = 0 for hc in [656,751].
  - vs_raw = 0 for vc in [490,491].
  - blank_raw = draw_valid.
- Alignment pipeline: a PIPE_DELAY-deep shift register of {hs,vs,blank}, advancing only on pix_en. With PIPE_DELAY=0, the outputs are the registered raw values with no extra delay.
- Frame events:
  - frame_start pulses on the pix_en cycle in which the counters move from (799,524) to (0,0).
  - frame_count increments on that same cycle, wrapping 255->0.
  - No pulse and no increment on reset release.
- Reset (synchronous, wins over all other activity):
  - toggle=0, hc=0, vc=0.
  - Every pipeline stage loaded with hs=1, vs=1, blank=0.
  - frame_start=0, frame_count=0, draw_valid=1 (position 0,0 is visible).
  - Asserting Reset mid-frame restarts at (0,0) on the next edge. The pipeline is flushed to idle values, not drained.
- All counter and compare arithmetic is unsigned at 10 bits. No counter ever holds a value outside its range.

## Timing
- First pix_en: second Clk edge after Reset deasserts. DrawX first reads 1 after that edge.
- Each (DrawX,DrawY) value is held for exactly 2 Clk.
- A raw hs/vs/blank transition at pixel tick N appears on the outputs at tick N+PIPE_DELAY.
- Line = 1600 Clk. Frame = 840 000 Clk. hs low for 192 Clk per line. vs low for 3200 Clk per frame.
- frame_start and a frame_count change occur on the same Clk edge. Consecutive pulses are exactly 840 000 Clk apart.

## Configuration
- VGA_TIMING_FRAME_STATS_EN defined: the frame_start and frame_count logic is built as described above.
- Not defined: frame_start is tied to 0 and frame_count is tied to 8'd0, with no registers. All other behaviour is identical.

## Test plan
- Reset held 3 Clk, then released -> DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_count=0; pix_en high on every second Clk from the second edge after release.
- Free-run one line, PIPE_DELAY=2 -> hs falls 2 ticks after DrawX reaches 656 and rises 2 ticks after DrawX reaches 752; low for exactly 192 Clk.
- Visible-area edge, PIPE_DELAY=2 -> draw_valid falls at DrawX=640; blank falls 4 Clk later; blank rises 4 Clk after DrawX returns to 0 on a visible line.
- Full frame -> vs low only while the delayed vc is 490..491; at (799,524)->(0,0), frame_start is high for 1 Clk and frame_count goes 0->1; after 256 frames, frame_count=0.
- Reset asserted at DrawX=300, DrawY=200 -> next edge gives DrawX=0, DrawY=0, blank=0, hs=1, vs=1; no frame_start pulse.
- Macro undefined, 2 frames run -> frame_start is always 0, frame_count is always 0, and hs/vs/blank traces match the macro-defined run.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel tick divider, h/v counters, and hs/vs/blank
// delayed to match the mapper pipeline. Frame stats built only with VGA_TIMING_FRAME_STATS_EN.
module vga_timing_gen #(
    parameter int unsigned PIPE_DELAY = 2,
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_clk,
    output logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       draw_valid,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam logic [9:0] HVis       = 10'(H_VISIBLE);
    localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] HMax       = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VVis       = 10'(V_VISIBLE);
    localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] VMax       = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    localparam sync_t SyncIdle = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    logic       toggle_q;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       line_end;
    sync_t      raw;
    sync_t      sync_out;

    // Pixel tick divider; pix_en is high in the cycle ending with the pixel_clk fall.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= ~toggle_q;
        end
    end

    assign pixel_clk = toggle_q;
    assign pix_en    = toggle_q;

    assign line_end = (hc_q >= HMax);

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (line_end) begin
                hc_d = 10'd0;
                vc_d = (vc_q >= VMax) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hc_q <= 10'd0;
            vc_q <= 10'd0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign DrawX      = hc_q;
    assign DrawY      = vc_q;
    assign draw_valid = (hc_q < HVis) && (vc_q < VVis);

    always_comb begin
        raw.hs    = ~((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
        raw.vs    = ~((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
        raw.blank = draw_valid;
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign sync_out = raw;
        end else begin : g_pipe
            sync_t pipe_q [PIPE_DELAY];

            // Reset flushes every stage to idle rather than letting old values drain.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                        pipe_q[i] <= SyncIdle;
                    end
                end else if (pix_en) begin
                    pipe_q[0] <= raw;
                    for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign sync_out = pipe_q[PIPE_DELAY-1];
        end
    endgenerate

    assign hs    = sync_out.hs;
    assign vs    = sync_out.vs;
    assign blank = sync_out.blank;

`ifdef VGA_TIMING_FRAME_STATS_EN
    logic       frame_end;
    logic       frame_start_q;
    logic [7:0] frame_count_q;

    assign frame_end = pix_en && line_end && (vc_q >= VMax);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            frame_start_q <= frame_end;
            if (frame_end) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
        end
    end

    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
`else
    assign frame_start = 1'b0;
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size instance for line-level timing and a shrunken
// instance (8x6 raster) for whole-frame and frame-counter wrap behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_STATS_EN
    localparam logic FsEn = 1'b1;
`else
    localparam logic FsEn = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pe;
        logic       pclk;
        logic       dv;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
        logic [7:0] fc;
    } outs_t;

    typedef struct {
        int    k;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_s = 1'b1;

    logic       pclk_a, pe_a, dv_a, hs_a, vs_a, bl_a, fs_a;
    logic [9:0] x_a, y_a;
    logic [7:0] fc_a;
    logic       pclk_b, pe_b, dv_b, hs_b, vs_b, bl_b, fs_b;
    logic [9:0] x_b, y_b;
    logic [7:0] fc_b;

    int tests_run = 0;
    int tests_failed = 0;
    int k = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .Clk        (clk),
        .Reset      (reset),
        .pixel_clk  (pclk_a),
        .pix_en     (pe_a),
        .DrawX      (x_a),
        .DrawY      (y_a),
        .draw_valid (dv_a),
        .hs         (hs_a),
        .vs         (vs_a),
        .blank      (bl_a),
        .frame_start(fs_a),
        .frame_count(fc_a)
    );

    vga_timing_gen #(
        .PIPE_DELAY(2),
        .H_VISIBLE (4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE (3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .Clk        (clk),
        .Reset      (reset_s),
        .pixel_clk  (pclk_b),
        .pix_en     (pe_b),
        .DrawX      (x_b),
        .DrawY      (y_b),
        .draw_valid (dv_b),
        .hs         (hs_b),
        .vs         (vs_b),
        .blank      (bl_b),
        .frame_start(fs_b),
        .frame_count(fc_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic adv_to(input int target);
        while (k < target) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at k=%0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at k=%0d: got x=%0d y=%0d pe=%b pclk=%b dv=%b hs=%b vs=%b bl=%b fs=%b fc=%0d, expected x=%0d y=%0d pe=%b pclk=%b dv=%b hs=%b vs=%b bl=%b fs=%b fc=%0d",
                     name, k, act.x, act.y, act.pe, act.pclk, act.dv, act.hs, act.vs, act.bl,
                     act.fs, act.fc, exp.x, exp.y, exp.pe, exp.pclk, exp.dv, exp.hs, exp.vs,
                     exp.bl, exp.fs, exp.fc);
        end
    endtask

    function automatic outs_t sample_a();
        outs_t o;
        o = '{x: x_a, y: y_a, pe: pe_a, pclk: pclk_a, dv: dv_a, hs: hs_a, vs: vs_a,
              bl: bl_a, fs: fs_a, fc: fc_a};
        return o;
    endfunction

    function automatic vec_t mk(input int kk, input int x, input int y, input logic pe,
                                input logic dv, input logic hs, input logic vs, input logic bl);
        vec_t v;
        v.k   = kk;
        v.exp = '{x: 10'(x), y: 10'(y), pe: pe, pclk: pe, dv: dv, hs: hs, vs: vs,
                  bl: bl, fs: 1'b0, fc: 8'd0};
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        int   hs_low;
        int   vs_low;
        int   fs_seen;

        // k counts Clk edges after the last edge that sampled Reset high.
        vecs.push_back(mk(0,    0,   0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1,    0,   0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(2,    1,   0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(3,    1,   0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(4,    2,   0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(1279, 639, 0, 1, 1, 1, 1, 1));
        vecs.push_back(mk(1280, 640, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1283, 641, 0, 1, 0, 1, 1, 1));
        vecs.push_back(mk(1284, 642, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1312, 656, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1315, 657, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(1316, 658, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1507, 753, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1508, 754, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1599, 799, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(1600, 0,   1, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1603, 1,   1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(1604, 2,   1, 0, 1, 1, 1, 1));

        // Full-size instance
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;

        foreach (vecs[i]) begin
            adv_to(vecs[i].k);
            check_outs($sformatf("line_vec%0d", i), sample_a(), vecs[i].exp);
        end

        hs_low = 0;
        while (k < 3204) begin
            step();
            if (!hs_a) hs_low++;
        end
        check("hs_low_clks_per_line", 32'(hs_low), 32'd192);

        adv_to(3800);
        check_outs("pre_reset_pos", sample_a(),
                   '{x: 10'd300, y: 10'd2, pe: 1'b0, pclk: 1'b0, dv: 1'b1, hs: 1'b1, vs: 1'b1,
                     bl: 1'b1, fs: 1'b0, fc: 8'd0});
        reset = 1'b1;
        step();
        check_outs("midframe_reset", sample_a(),
                   '{x: 10'd0, y: 10'd0, pe: 1'b0, pclk: 1'b0, dv: 1'b1, hs: 1'b1, vs: 1'b1,
                     bl: 1'b0, fs: 1'b0, fc: 8'd0});
        reset = 1'b0;
        k = 0;
        adv_to(2);
        check_outs("after_midframe_release", sample_a(),
                   '{x: 10'd1, y: 10'd0, pe: 1'b0, pclk: 1'b0, dv: 1'b1, hs: 1'b1, vs: 1'b1,
                     bl: 1'b0, fs: 1'b0, fc: 8'd0});
        reset = 1'b1;

        // Small instance: 8 px/line, 6 lines/frame, 96 Clk per frame
        repeat (3) @(posedge clk);
        #1;
        reset_s = 1'b0;
        k = 0;
        check("small_reset_fc", 32'(fc_b), 32'd0);
        check("small_reset_fs", 32'(fs_b), 32'd0);
        adv_to(1);
        check("small_release_fs", 32'(fs_b), 32'd0);
        adv_to(67);
        check("small_vs_before", 32'(vs_b), 32'd1);
        adv_to(68);
        check("small_vs_fall", 32'(vs_b), 32'd0);
        adv_to(83);
        check("small_vs_last_low", 32'(vs_b), 32'd0);
        adv_to(84);
        check("small_vs_rise", 32'(vs_b), 32'd1);
        adv_to(95);
        check("small_last_pos", 32'({x_b, y_b}), 32'({10'd7, 10'd5}));
        check("small_fs_before_wrap", 32'(fs_b), 32'd0);
        check("small_fc_before_wrap", 32'(fc_b), 32'd0);
        adv_to(96);
        check("small_wrap_pos", 32'({x_b, y_b}), 32'd0);
        check("small_fs_pulse", 32'(fs_b), 32'(FsEn));
        check("small_fc_one", 32'(fc_b), FsEn ? 32'd1 : 32'd0);
        adv_to(97);
        check("small_fs_one_clk", 32'(fs_b), 32'd0);

        hs_low  = 0;
        vs_low  = 0;
        fs_seen = 0;
        while (k < 193) begin
            step();
            if (!hs_b) hs_low++;
            if (!vs_b) vs_low++;
            if (fs_b) fs_seen++;
        end
        check("small_hs_low_per_frame", 32'(hs_low), 32'd24);
        check("small_vs_low_per_frame", 32'(vs_low), 32'd16);
        check("small_fs_per_frame", 32'(fs_seen), FsEn ? 32'd1 : 32'd0);
        check("small_fc_two", 32'(fc_b), FsEn ? 32'd2 : 32'd0);

        adv_to(96 * 255 + 1);
        check("small_fc_255", 32'(fc_b), FsEn ? 32'd255 : 32'd0);
        adv_to(96 * 256);
        check("small_fc_wrap", 32'(fc_b), 32'd0);
        check("small_fs_wrap", 32'(fs_b), 32'(FsEn));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
